// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: class enum, opcode constants, FSM states.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_L     = 3'd2,
    CLS_S     = 3'd3,
    CLS_B     = 3'd4,
    CLS_LUI   = 3'd5,
    CLS_AUIPC = 3'd6
  } instr_class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  // True when v is representable as a signed value of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] upper;
    upper = 32'($signed(v) >>> (bits - 1));
    return (upper == 32'hFFFF_FFFF) || (upper == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request / instruction-memory write bundle between the loader front end and instr_encoder.
interface instr_encoder_if #(
  parameter int unsigned DEPTH = 256
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          i_Start;
  logic          i_Done;
  logic          i_Valid;
  logic          o_Ready;
  logic [2:0]    i_Class;
  logic [4:0]    i_Rd;
  logic [4:0]    i_Rs1;
  logic [4:0]    i_Rs2;
  logic [2:0]    i_Funct3;
  logic [6:0]    i_Funct7;
  logic [31:0]   i_Imm;
  logic          o_IMemWe;
  logic [31:0]   o_IMemAddr;
  logic [31:0]   o_IMemData;
  logic [CW-1:0] o_Count;
  logic          o_Err;
  logic          o_Busy;
  logic          o_Done;

  modport master (
    output i_Start, i_Done, i_Valid, i_Class, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Imm,
    input  o_Ready, o_IMemWe, o_IMemAddr, o_IMemData, o_Count, o_Err, o_Busy, o_Done
  );

  modport slave (
    input  i_Start, i_Done, i_Valid, i_Class, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Imm,
    output o_Ready, o_IMemWe, o_IMemAddr, o_IMemData, o_Count, o_Err, o_Busy, o_Done
  );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational class/field to RV32I word packer with a request-valid flag.
// INSTR_ENCODER_IMM_CHECK_EN adds immediate range checking to the valid flag.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic class_ok_c;
  logic range_ok_c;

  always_comb begin
    word_o     = '0;
    class_ok_c = 1'b1;
    case (instr_class_e'(class_i))
      CLS_R:     word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      CLS_I:     word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
      CLS_L:     word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_L};
      CLS_S:     word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
      CLS_B:     word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_B};
      CLS_LUI:   word_o = {imm_i[31:12], rd_i, OP_LUI};
      CLS_AUIPC: word_o = {imm_i[31:12], rd_i, OP_AUIPC};
      default:   class_ok_c = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  always_comb begin
    range_ok_c = 1'b1;
    case (instr_class_e'(class_i))
      CLS_I, CLS_L, CLS_S: range_ok_c = fits_signed(imm_i, 12);
      CLS_B:               range_ok_c = fits_signed(imm_i, 13) && !imm_i[0];
      CLS_LUI, CLS_AUIPC:  range_ok_c = (imm_i[11:0] == 12'd0);
      default:             range_ok_c = 1'b1;
    endcase
  end
`else
  logic unused_imm_c;
  assign unused_imm_c = imm_i[0];
  assign range_ok_c   = 1'b1;
`endif

  assign valid_o = class_ok_c && range_ok_c;

endmodule

// File: rtl/instr_encoder.sv
// Session FSM, address/count tracking and registered instruction-memory write port.
// Build option INSTR_ENCODER_IMM_CHECK_EN enables immediate range rejection in the packer.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic     i_clk,
  input  logic     i_rst,
  instr_encoder_if.slave bus
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   LAST_C  = CW'(DEPTH - 1);

  enc_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]   word_c;
  logic          pack_valid_c;
  logic          accept_c;
  logic          write_c;
  logic          restart_c;

  instr_field_pack u_pack (
    .class_i  (bus.i_Class),
    .rd_i     (bus.i_Rd),
    .rs1_i    (bus.i_Rs1),
    .rs2_i    (bus.i_Rs2),
    .funct3_i (bus.i_Funct3),
    .funct7_i (bus.i_Funct7),
    .imm_i    (bus.i_Imm),
    .word_o   (word_c),
    .valid_o  (pack_valid_c)
  );

  assign accept_c  = (state_q == ST_LOAD) && bus.i_Valid;
  assign write_c   = accept_c && pack_valid_c;
  assign restart_c = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.i_Start;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; i_Done takes priority over filling the last slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.i_Start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.i_Done)                          state_d = ST_DONE;
        else if (write_c && (count_q == LAST_C)) state_d = ST_FULL;
      end
      ST_FULL: if (bus.i_Done)  state_d = ST_DONE;
      ST_DONE: if (bus.i_Start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    count_d    = count_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    we_d       = write_c;
    err_d      = accept_c && !pack_valid_c;
    ready_d    = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_FULL);
    done_d     = (state_d == ST_DONE);
    if (restart_c) begin
      count_d = '0;
      addr_d  = BASE_ADDR;
    end
    if (write_c) begin
      mem_addr_d = addr_q;
      mem_data_d = word_c;
      addr_d     = addr_q + 32'd4;
      count_d    = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      we_q       <= we_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_Ready    = ready_q;
  assign bus.o_IMemWe   = we_q;
  assign bus.o_IMemAddr = mem_addr_q;
  assign bus.o_IMemData = mem_data_q;
  assign bus.o_Count    = count_q;
  assign bus.o_Err      = err_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder (DEPTH=256 main instance, DEPTH=2 fill instance).
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.DEPTH(256)) bus1 ();
  instr_encoder_if #(.DEPTH(2))   bus2 ();

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(256)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus1)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(2)) dut2 (
    .i_clk (clk), .i_rst (rst), .bus (bus2)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [8];

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  localparam logic [31:0] DONE_ADDR  = 32'h0000_0020;
  localparam logic [31:0] DONE_COUNT = 32'd9;
`else
  localparam logic [31:0] DONE_ADDR  = 32'h0000_0024;
  localparam logic [31:0] DONE_COUNT = 32'd10;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 32'(bus1.o_Ready),  32'd0);
    chk({tag, ".we"},    32'(bus1.o_IMemWe), 32'd0);
    chk({tag, ".addr"},  bus1.o_IMemAddr,    32'h0000_0000);
    chk({tag, ".data"},  bus1.o_IMemData,    32'd0);
    chk({tag, ".count"}, 32'(bus1.o_Count),  32'd0);
    chk({tag, ".err"},   32'(bus1.o_Err),    32'd0);
    chk({tag, ".busy"},  32'(bus1.o_Busy),   32'd0);
    chk({tag, ".done"},  32'(bus1.o_Done),   32'd0);
  endtask

  task automatic drive1(input vec_t v);
    bus1.i_Class  = v.cls;
    bus1.i_Rd     = v.rd;
    bus1.i_Rs1    = v.rs1;
    bus1.i_Rs2    = v.rs2;
    bus1.i_Funct3 = v.f3;
    bus1.i_Funct7 = v.f7;
    bus1.i_Imm    = v.imm;
  endtask

  initial begin
    vec_t v_tmp;

    // cls, rd, rs1, rs2, f3, f7, imm, expected word
    vecs[0] = '{3'd0, 5'd3, 5'd1,  5'd2,  3'd0, 7'h00, 32'h0,         32'h002081B3}; // add x3,x1,x2
    vecs[1] = '{3'd0, 5'd5, 5'd6,  5'd7,  3'd0, 7'h20, 32'h0,         32'h407302B3}; // sub x5,x6,x7
    vecs[2] = '{3'd1, 5'd1, 5'd0,  5'd0,  3'd0, 7'h00, 32'd5,         32'h00500093}; // addi x1,x0,5
    vecs[3] = '{3'd3, 5'd0, 5'd1,  5'd2,  3'd2, 7'h00, 32'd8,         32'h0020A423}; // sw x2,8(x1)
    vecs[4] = '{3'd2, 5'd4, 5'd2,  5'd0,  3'd2, 7'h00, 32'hFFFF_FFFF, 32'hFFF12203}; // lw x4,-1(x2)
    vecs[5] = '{3'd4, 5'd0, 5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE208EE3}; // beq x1,x2,-4
    vecs[6] = '{3'd5, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h123452B7}; // lui, junk fields
    vecs[7] = '{3'd6, 5'd1, 5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_1000, 32'h00001097}; // auipc x1,1

    bus1.i_Start = 1'b0; bus1.i_Done = 1'b0; bus1.i_Valid = 1'b0;
    bus2.i_Start = 1'b0; bus2.i_Done = 1'b0; bus2.i_Valid = 1'b0;
    drive1(vecs[0]);
    bus2.i_Class = 3'd1; bus2.i_Rd = 5'd1; bus2.i_Rs1 = 5'd0; bus2.i_Rs2 = 5'd0;
    bus2.i_Funct3 = 3'd0; bus2.i_Funct7 = 7'd0; bus2.i_Imm = 32'd5;

    step(); step();
    chk_reset("reset");
    rst = 1'b0;

    // i_Done ignored in IDLE
    bus1.i_Done = 1'b1; step(); bus1.i_Done = 1'b0;
    chk("idle_done.done", 32'(bus1.o_Done), 32'd0);
    chk("idle_done.busy", 32'(bus1.o_Busy), 32'd0);

    bus1.i_Start = 1'b1; step(); bus1.i_Start = 1'b0;
    chk("start.busy",  32'(bus1.o_Busy),  32'd1);
    chk("start.ready", 32'(bus1.o_Ready), 32'd1);
    chk("start.count", 32'(bus1.o_Count), 32'd0);

    // Back-to-back beats, one write per cycle
    for (int i = 0; i < 8; i++) begin
      drive1(vecs[i]);
      bus1.i_Valid = 1'b1;
      step();
      chk($sformatf("vec%0d.we", i),    32'(bus1.o_IMemWe), 32'd1);
      chk($sformatf("vec%0d.addr", i),  bus1.o_IMemAddr,    32'(i * 4));
      chk($sformatf("vec%0d.data", i),  bus1.o_IMemData,    vecs[i].exp_word);
      chk($sformatf("vec%0d.count", i), 32'(bus1.o_Count),  32'(i + 1));
    end
    bus1.i_Valid = 1'b0;
    step();
    chk("idle_beat.we",    32'(bus1.o_IMemWe), 32'd0);
    chk("idle_beat.count", 32'(bus1.o_Count),  32'd8);

    // Undefined class: accepted, error pulse, nothing written
    v_tmp = vecs[0];
    v_tmp.cls = 3'd7;
    drive1(v_tmp);
    bus1.i_Valid = 1'b1; step(); bus1.i_Valid = 1'b0;
    chk("bad_class.err",   32'(bus1.o_Err),    32'd1);
    chk("bad_class.we",    32'(bus1.o_IMemWe), 32'd0);
    chk("bad_class.count", 32'(bus1.o_Count),  32'd8);
    step();
    chk("bad_class.err_clear", 32'(bus1.o_Err), 32'd0);

    // addi x1,x0,4096: out of range
    v_tmp = vecs[2];
    v_tmp.imm = 32'd4096;
    drive1(v_tmp);
    bus1.i_Valid = 1'b1; step(); bus1.i_Valid = 1'b0;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    chk("imm4096.err",   32'(bus1.o_Err),    32'd1);
    chk("imm4096.we",    32'(bus1.o_IMemWe), 32'd0);
    chk("imm4096.count", 32'(bus1.o_Count),  32'd8);
`else
    chk("imm4096.err",   32'(bus1.o_Err),    32'd0);
    chk("imm4096.we",    32'(bus1.o_IMemWe), 32'd1);
    chk("imm4096.data",  bus1.o_IMemData,    32'h00000093);
    chk("imm4096.addr",  bus1.o_IMemAddr,    32'h0000_0020);
    chk("imm4096.count", 32'(bus1.o_Count),  32'd9);
`endif

    // Valid together with Done: beat written, then DONE
    drive1(vecs[0]);
    bus1.i_Valid = 1'b1; bus1.i_Done = 1'b1; step();
    bus1.i_Valid = 1'b0; bus1.i_Done = 1'b0;
    chk("vdone.we",    32'(bus1.o_IMemWe), 32'd1);
    chk("vdone.addr",  bus1.o_IMemAddr,    DONE_ADDR);
    chk("vdone.data",  bus1.o_IMemData,    32'h002081B3);
    chk("vdone.count", 32'(bus1.o_Count),  DONE_COUNT);
    chk("vdone.done",  32'(bus1.o_Done),   32'd1);
    chk("vdone.busy",  32'(bus1.o_Busy),   32'd0);
    chk("vdone.ready", 32'(bus1.o_Ready),  32'd0);

    // Restart from DONE: address and count start over
    bus1.i_Start = 1'b1; step(); bus1.i_Start = 1'b0;
    chk("restart.count", 32'(bus1.o_Count), 32'd0);
    chk("restart.done",  32'(bus1.o_Done),  32'd0);
    drive1(vecs[2]);
    bus1.i_Valid = 1'b1; step(); bus1.i_Valid = 1'b0;
    chk("restart.addr",  bus1.o_IMemAddr,   32'h0000_0000);
    chk("restart.data",  bus1.o_IMemData,   32'h00500093);
    chk("restart.count1", 32'(bus1.o_Count), 32'd1);

    // i_Start ignored in LOAD
    bus1.i_Start = 1'b1; step(); bus1.i_Start = 1'b0;
    chk("load_start.count", 32'(bus1.o_Count), 32'd1);

    // Reset the cycle after an accept
    bus1.i_Valid = 1'b1; step(); bus1.i_Valid = 1'b0;
    chk("pre_rst.we", 32'(bus1.o_IMemWe), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset("rst_after_accept");

    // Reset coinciding with a beat: no write pulse
    bus1.i_Start = 1'b1; step(); bus1.i_Start = 1'b0;
    bus1.i_Valid = 1'b1; rst = 1'b1; step();
    bus1.i_Valid = 1'b0; rst = 1'b0;
    chk_reset("rst_with_beat");
    step();
    chk("rst_with_beat.we_after", 32'(bus1.o_IMemWe), 32'd0);

    // DEPTH=2: three beats, two writes, then FULL
    bus2.i_Start = 1'b1; step(); bus2.i_Start = 1'b0;
    bus2.i_Valid = 1'b1;
    step();
    chk("full.b1.we",    32'(bus2.o_IMemWe), 32'd1);
    chk("full.b1.count", 32'(bus2.o_Count),  32'd1);
    chk("full.b1.ready", 32'(bus2.o_Ready),  32'd1);
    step();
    chk("full.b2.we",    32'(bus2.o_IMemWe),  32'd1);
    chk("full.b2.addr",  bus2.o_IMemAddr,     32'h0000_0004);
    chk("full.b2.data",  bus2.o_IMemData,     32'h00500093);
    chk("full.b2.count", 32'(bus2.o_Count),   32'd2);
    chk("full.b2.ready", 32'(bus2.o_Ready),   32'd0);
    chk("full.b2.busy",  32'(bus2.o_Busy),    32'd1);
    step();
    chk("full.b3.we",    32'(bus2.o_IMemWe), 32'd0);
    chk("full.b3.count", 32'(bus2.o_Count),  32'd2);
    bus2.i_Valid = 1'b0;
    bus2.i_Done  = 1'b1; step(); bus2.i_Done = 1'b0;
    chk("full.done", 32'(bus2.o_Done), 32'd1);
    chk("full.busy", 32'(bus2.o_Busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles RV32I instruction words from decoded control fields and writes them sequentially into instruction memory. Performs the inverse of the core's opcode/control decode: a field-level request in, a 32-bit encoded word out. Sits between the bench/boot-loader front end and the instruction memory write port, so programs can be built from decoded fields before the core is released from reset.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- DEPTH, 256: maximum number of words written per load session (≥1).

Clock and reset: one clock; reset is synchronous and active-high.

- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_Start  in  1  begin a load session.
- i_Done  in  1  end the load session.
- i_Valid  in  1  request valid.
- o_Ready  out  1  request accepted when i_Valid && o_Ready.
- i_Class  in  3  instruction class (package enum).
- i_Rd, i_Rs1, i_Rs2  in  5 each  register fields.
- i_Funct3  in  3  funct3 field.
- i_Funct7  in  7  funct7 field (R class only).
- i_Imm  in  32  immediate, in the instruction's architectural byte-offset form.
- o_IMemWe  out  1  instruction memory write enable.
- o_IMemAddr  out  32  write byte address.
- o_IMemData  out  32  encoded word.
- o_Count  out  $clog2(DEPTH+1)  words written this session.
- o_Err  out  1  one-cycle pulse on a rejected request.
- o_Busy  out  1  state is LOAD or FULL.
- o_Done  out  1  state is DONE.

## Operation
- FSM states: IDLE, LOAD, FULL, DONE.
  - IDLE: i_Start → LOAD; address reset to BASE_ADDR, count reset to 0.
  - LOAD: o_Ready = 1. An accepted request increments count. If count reaches DEPTH → FULL. i_Done → DONE.
  - FULL: o_Ready = 0. i_Done → DONE.
  - DONE: o_Done = 1. i_Start → LOAD, which restarts the address and count.
- Encoding by class:
  - R (0110011): {f7, rs2, rs1, f3, rd, op}
  - I (0010011) and L (0000011): {imm[11:0], rs1, f3, rd, op}
  - S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - LUI (0110111) and AUIPC (0010111): {imm[31:12], rd, op}
- Unused fields are ignored for each class.
- Undefined class values (3'd7): the request is accepted, o_Err pulses, nothing is written, and count/address hold.
- Address advances by 4 for each written word. Address arithmetic is 32-bit and wraps modulo 2^32.
- Simultaneous i_Valid and i_Done in LOAD: the beat is accepted and written; the state then moves to DONE.
- i_Start is ignored outside IDLE and DONE.
- i_Done is ignored in IDLE and DONE.

## Timing
- Reset values: o_Ready 0, o_IMemWe 0, o_IMemAddr BASE_ADDR, o_IMemData 0, o_Count 0, o_Err 0, o_Busy 0, o_Done 0; state IDLE.
- Request accepted at edge N: o_IMemWe = 1 with address and data valid during cycle N+1 (one registered stage). o_Count updates at edge N.
- o_Err pulses in cycle N+1 for a request rejected at edge N.
- Back-to-back accepts sustain one word per cycle.
- The last slot (count = DEPTH−1) is accepted, and o_Ready drops in the next cycle.
- Reset asserted mid-session drops any pending write; o_IMemWe is 0 in the cycle after reset.

## Configuration
- Macro INSTR_ENCODER_IMM_CHECK_EN.
- Defined: immediate range checks apply.
  - I/L/S: i_Imm must be within signed 12-bit range.
  - B: i_Imm must be within signed 13-bit range and even.
  - LUI/AUIPC: i_Imm[11:0] must be 0.
  - A failing request is accepted, o_Err pulses, and nothing is written.
- Undefined: out-of-range bits are silently truncated. o_Err fires only for undefined classes.

## Structure
- Shared package instr_enc_pkg:
  - class enum (R=0, I=1, L=2, S=3, B=4, LUI=5, AUIPC=6);
  - the seven 7-bit opcode constants, identical to those used by the core's opcode decode;
  - FSM state enum.
- Sub-module instr_field_pack: purely combinational class/field → word packer, plus a valid flag (and the range check when the macro is on). The top level holds the FSM, counters and output registers.

## Test plan
- Start, then R: rd=3, rs1=1, rs2=2, f3=0, f7=0 → one write at 0x0000_0000 of data 0x002081B3; count 1.
- Back-to-back I addi x1,x0,5, then S sw x2,8(x1) → 0x00500093 at 0x0, then 0x0020A423 at 0x4 on consecutive cycles.
- B beq x1,x2,-4 → 0xFE208EE3.
- LUI x5, imm 0x12345000 → 0x123452B7.
- DEPTH=2 with three valid beats → two writes, o_Ready low after the second, state FULL. i_Done → o_Done=1.
- Macro defined, I-class imm=4096 → o_Err pulse, no write, count unchanged. Macro undefined → write 0x00000093 (x1, rs1=0, imm truncated to 0).
- Reset asserted in the cycle after an accept → no o_IMemWe pulse; all outputs at reset values.
